// File: rtl/sga_render_sequencer.sv
// sga_render_sequencer: per request clears the framebuffer, draws the apple, then draws the snake head and body.
module sga_render_sequencer #(
    parameter int COORD_W = 4,
    parameter int SIZE_W  = 6
) (
    input  logic                 clock,
    input  logic                 restart_n,
    input  logic                 render_start,
    input  logic [SIZE_W-1:0]    snake_size,
    input  logic [COORD_W-1:0]   apple_x,
    input  logic [COORD_W-1:0]   apple_y,
    output logic [SIZE_W-1:0]    body_rd_addr,
    input  logic [COORD_W-1:0]   body_x,
    input  logic [COORD_W-1:0]   body_y,
    output logic [2*COORD_W-1:0] fb_addr,
    output logic [1:0]           fb_data,
    output logic                 fb_we,
    input  logic                 fb_ack,
    output logic                 busy,
    output logic                 render_finish,
    output logic [2:0]           db_state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        APPLE_WR  = 3'd2,
        BODY_RD   = 3'd3,
        BODY_WAIT = 3'd4,
        BODY_WR   = 3'd5,
        DONE      = 3'd6
    } state_t;
    state_t state, state_nx;
    logic [2*COORD_W-1:0] cnt;
    logic [SIZE_W-1:0] size_q, idx;
    logic [COORD_W-1:0] ax, ay, bx, by;
    logic last_seg;
    assign last_seg = idx == size_q - SIZE_W'(1);
    always_ff @(posedge clock) begin
        if (!restart_n) state <= IDLE;
        else            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = render_start ? CLEAR : IDLE;
            CLEAR:     state_nx = (fb_ack && &cnt) ? APPLE_WR : CLEAR;
            APPLE_WR:  state_nx = fb_ack ? (size_q != '0 ? BODY_RD : DONE) : APPLE_WR;
            BODY_RD:   state_nx = BODY_WAIT;
            BODY_WAIT: state_nx = BODY_WR;
            BODY_WR:   state_nx = fb_ack ? (last_seg ? DONE : BODY_RD) : BODY_WR;
            default:   state_nx = IDLE;
        endcase
    end
    always_comb begin
        fb_we         = state == CLEAR || state == APPLE_WR || state == BODY_WR;
        fb_addr       = state == CLEAR ? cnt : state == APPLE_WR ? {ay, ax} : state == BODY_WR ? {by, bx} : '0;
        fb_data       = state == APPLE_WR ? 2'b11 : state == BODY_WR ? (idx == '0 ? 2'b10 : 2'b01) : 2'b00;
        busy          = state != IDLE;
        render_finish = state == DONE;
        db_state      = state;
        body_rd_addr  = idx;
    end
    // index returns to 0 after the last segment so the read address rests at the head between frames
    always_ff @(posedge clock) begin
        if (!restart_n) begin
            cnt    <= '0;
            idx    <= '0;
            size_q <= '0;
            ax     <= '0;
            ay     <= '0;
            bx     <= '0;
            by     <= '0;
        end else begin
            if (state == IDLE && render_start) begin
                size_q <= snake_size;
                ax     <= apple_x;
                ay     <= apple_y;
                cnt    <= '0;
                idx    <= '0;
            end
            if (state == CLEAR && fb_ack) cnt <= cnt + (2*COORD_W)'(1);
            if (state == BODY_WAIT) begin
                bx <= body_x;
                by <= body_y;
            end
            if (state == BODY_WR && fb_ack) idx <= last_seg ? '0 : idx + SIZE_W'(1);
        end
    end
endmodule

// File: tb/tb_sga_render_sequencer.sv
// tb_sga_render_sequencer: scoreboard bench; stimulus queues expected writes, a monitor pops on each accepted write.
module tb_sga_render_sequencer;
    logic clock = 1'b0;
    logic restart_n = 1'b0;
    logic render_start = 1'b0;
    logic [5:0] snake_size = '0;
    logic [3:0] apple_x = '0, apple_y = '0;
    logic [5:0] body_rd_addr;
    logic [3:0] body_x = '0, body_y = '0;
    logic [7:0] fb_addr;
    logic [1:0] fb_data;
    logic fb_we;
    logic fb_ack = 1'b1;
    logic busy, render_finish;
    logic [2:0] db_state;
    int passed = 0, total = 0;
    logic [9:0] sb[$];
    logic [3:0] mx[64], my[64];
    bit ack_rnd = 0, track_rd = 0, rd_moved = 0, have_prev = 0;
    logic p_we, p_ack;
    logic [7:0] p_addr;
    logic [1:0] p_data;
    sga_render_sequencer dut (
        .clock(clock), .restart_n(restart_n), .render_start(render_start),
        .snake_size(snake_size), .apple_x(apple_x), .apple_y(apple_y),
        .body_rd_addr(body_rd_addr), .body_x(body_x), .body_y(body_y),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ack(fb_ack),
        .busy(busy), .render_finish(render_finish), .db_state(db_state)
    );
    always #5 clock = ~clock;
    always @(posedge clock) begin
        body_x <= mx[body_rd_addr];
        body_y <= my[body_rd_addr];
    end
    initial forever begin
        @(posedge clock);
        #1 fb_ack = ack_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    always @(negedge clock) begin
        if (!restart_n) have_prev = 0;
        else begin
            if (have_prev && p_we && !p_ack) begin
                chk("hold_we", fb_we, 1);
                chk("hold_addr", fb_addr, p_addr);
                chk("hold_data", fb_data, p_data);
            end
            if (fb_we && fb_ack) begin
                if (sb.size() == 0) chk("write_extra", {fb_addr, fb_data}, 32'hFFFF_FFFF);
                else chk("write", {fb_addr, fb_data}, sb.pop_front());
            end
            if (track_rd && body_rd_addr != '0) rd_moved = 1;
            have_prev = 1;
            p_we = fb_we; p_ack = fb_ack; p_addr = fb_addr; p_data = fb_data;
        end
    end
    task automatic setup(input logic [5:0] n, input logic [3:0] x, input logic [3:0] y, input bit hand);
        snake_size = n; apple_x = x; apple_y = y;
        for (int i = 0; i < 256; i++) sb.push_back({8'(i), 2'b00});
        if (hand) begin
            sb.push_back({8'h95, 2'b11});
            sb.push_back({8'h22, 2'b10});
            sb.push_back({8'h32, 2'b01});
            sb.push_back({8'h42, 2'b01});
        end else begin
            sb.push_back({y, x, 2'b11});
            for (int s = 0; s < int'(n); s++) sb.push_back({my[s], mx[s], s == 0 ? 2'b10 : 2'b01});
        end
    endtask
    // lat counts rising edges after the accepting edge until render_finish is seen
    task automatic wait_finish(input int exp_lat, input bit chk_lat, input bit poke);
        int lat = 0;
        bit poked = 0;
        snake_size = 6'h3F; apple_x = 4'hF; apple_y = 4'hE;
        @(negedge clock);
        while (!render_finish && lat < 2000) begin
            if (poke && !poked && db_state == 3'd5) begin
                render_start = 1;
                poked = 1;
            end
            @(posedge clock);
            #1 render_start = 0;
            lat++;
            @(negedge clock);
        end
        if (chk_lat) chk("finish_lat", lat, exp_lat);
        else chk("finish_seen", render_finish, 1);
        if (poke) chk("poked", poked, 1);
        repeat (3) begin
            @(negedge clock);
            chk("idle_state", db_state, 0);
            chk("idle_busy", busy, 0);
        end
        chk("sb_empty", sb.size(), 0);
        sb.delete();
    endtask
    task automatic frame(input logic [5:0] n, input logic [3:0] x, input logic [3:0] y,
                         input bit hand, input int exp_lat, input bit chk_lat, input bit poke);
        @(posedge clock);
        #1 setup(n, x, y, hand);
        render_start = 1;
        @(posedge clock);
        #1 render_start = 0;
        wait_finish(exp_lat, chk_lat, poke);
    endtask
    initial begin
        for (int i = 0; i < 64; i++) begin mx[i] = 4'(i); my[i] = 4'(i + 7); end
        mx[0] = 2; my[0] = 2; mx[1] = 2; my[1] = 3; mx[2] = 2; my[2] = 4; mx[3] = 7; my[3] = 4'hA;
        render_start = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_we", fb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finish", render_finish, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_data, 0);
        chk("rst_rdaddr", body_rd_addr, 0);
        chk("rst_state", db_state, 0);
        setup(6'd3, 4'd5, 4'd9, 1);
        restart_n = 1;
        @(posedge clock);
        #1 render_start = 0;
        chk("start_after_rst", db_state, 1);
        wait_finish(266, 1, 0);
        track_rd = 1; rd_moved = 0;
        frame(6'd0, 4'd3, 4'd12, 0, 257, 1, 0);
        track_rd = 0;
        chk("size0_rdaddr_still", rd_moved, 0);
        ack_rnd = 1;
        frame(6'd3, 4'd5, 4'd9, 1, 0, 0, 0);
        ack_rnd = 0;
        frame(6'd1, 4'd2, 4'd2, 0, 260, 1, 0);
        frame(6'd4, 4'd0, 4'd15, 0, 269, 1, 1);
        @(posedge clock);
        #1 setup(6'd3, 4'd1, 4'd1, 0);
        render_start = 1;
        @(posedge clock);
        #1 render_start = 0;
        repeat (20) @(posedge clock);
        #1 restart_n = 0;
        @(posedge clock);
        #1;
        chk("midrst_state", db_state, 0);
        chk("midrst_we", fb_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", fb_addr, 0);
        sb.delete();
        repeat (3) begin
            @(negedge clock);
            chk("midrst_finish", render_finish, 0);
        end
        restart_n = 1;
        frame(6'd2, 4'd9, 4'd1, 0, 263, 1, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
